// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Sequencing controller for the multicycle MIPS core. Consumes decoder
//   classification flags, raw opcode/funct and the ALU zero flag. Produces
//   per-cycle datapath enables and mux selects. Also runs the multiplier-done
//   and UART receive-valid handshakes.
//
//   Optional feature macro: MULTICYCLE_MULT_WAIT_EN
//     defined   : MULT is followed by MULTWAIT, which holds until mult_done.
//     undefined : MULTWAIT does not exist, mult_done is ignored, MULT -> FETCH.
//
// Ports
//   clk, reset        rising-edge clock, async active-low reset
//   opcode, funct     IR[31:26], IR[5:0]
//   flag_*            decoder classification (flag_J_type==2 means jr)
//   mult_operation,
//   mflo_flag         decoder flags
//   alu_srcb_dec      decoder ALU operand-B select
//   zero              ALU zero flag (combinational)
//   mult_done         multiplier result valid
//   uart_rx_valid     UART RX buffer holds a byte
//   iord .. uart_rx_ack  datapath controls (Moore, decoded from state)
//   state_o           current state, debug only
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       flag_R_type,
  input  logic       flag_lw,
  input  logic       flag_sw,
  input  logic [1:0] flag_J_type,
  input  logic       mult_operation,
  input  logic       mflo_flag,
  input  logic [1:0] alu_srcb_dec,
  input  logic       zero,
  input  logic       mult_done,
  input  logic       uart_rx_valid,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [1:0] alu_force,
  output logic       reg_write,
  output logic       mult_start,
  output logic       uart_rx_ack,
  output logic [4:0] state_o
);

  typedef enum logic [4:0] {
    ST_RST      = 5'd0,
    ST_FETCH    = 5'd1,
    ST_DECODE   = 5'd2,
    ST_MEMADR   = 5'd3,
    ST_MEMREAD  = 5'd4,
    ST_MEMWB    = 5'd5,
    ST_MEMWRITE = 5'd6,
    ST_EXEC     = 5'd7,
    ST_ALUWB    = 5'd8,
    ST_BRANCH   = 5'd9,
    ST_JUMP     = 5'd10,
    ST_JR       = 5'd11,
    ST_MULT     = 5'd12,
    ST_UARTWAIT = 5'd13,
    ST_UARTWB   = 5'd14
`ifdef MULTICYCLE_MULT_WAIT_EN
    , ST_MULTWAIT = 5'd15
`endif
  } state_t;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_UART = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  state_t r_state;
  state_t w_dispatch;
  logic   w_i_alu;

  // funct is fully classified by the decoder; mult_done only matters with
  // the wait feature. Folded here so they are consumed.
`ifdef MULTICYCLE_MULT_WAIT_EN
  wire w_unused = ^funct;
`else
  wire w_unused = ^{funct, mult_done};
`endif

  assign w_i_alu = (opcode == OP_ADDI) || (opcode == OP_SLTI) ||
                   (opcode == OP_ANDI) || (opcode == OP_ORI)  ||
                   (opcode == OP_LUI);

  // Priority dispatch out of DECODE. I-type ALU ops are tested first because
  // the decoder also raises flag_sw for lui.
  always_comb begin
    w_dispatch = ST_FETCH;
    if (w_i_alu)                                  w_dispatch = ST_EXEC;
    else if (flag_lw || flag_sw)                  w_dispatch = ST_MEMADR;
    else if (opcode == OP_BEQ || opcode == OP_BNE) w_dispatch = ST_BRANCH;
    else if (opcode == OP_J || opcode == OP_JAL)  w_dispatch = ST_JUMP;
    else if (flag_R_type && flag_J_type == 2'd2)  w_dispatch = ST_JR;
    else if (opcode == OP_UART)                   w_dispatch = ST_UARTWAIT;
    else if (flag_R_type && mult_operation)       w_dispatch = ST_MULT;
    else if (flag_R_type && mflo_flag)            w_dispatch = ST_ALUWB;
    else if (flag_R_type)                         w_dispatch = ST_EXEC;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RST;
    end else begin
      case (r_state)
        ST_RST:      r_state <= ST_FETCH;
        ST_FETCH:    r_state <= ST_DECODE;
        ST_DECODE:   r_state <= w_dispatch;
        ST_MEMADR:   r_state <= flag_lw ? ST_MEMREAD : ST_MEMWRITE;
        ST_MEMREAD:  r_state <= ST_MEMWB;
        ST_EXEC:     r_state <= ST_ALUWB;
`ifdef MULTICYCLE_MULT_WAIT_EN
        ST_MULT:     r_state <= ST_MULTWAIT;
        ST_MULTWAIT: if (mult_done) r_state <= ST_FETCH;
`else
        ST_MULT:     r_state <= ST_FETCH;
`endif
        ST_UARTWAIT: if (uart_rx_valid) r_state <= ST_UARTWB;
        // MEMWB, MEMWRITE, ALUWB, BRANCH, JUMP, JR, UARTWB and any unused
        // code all return to FETCH.
        default:     r_state <= ST_FETCH;
      endcase
    end
  end

  // Moore decode; only BRANCH looks at an input (zero) for pc_en.
  always_comb begin
    iord        = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'd0;
    alu_srca    = 1'b0;
    alu_srcb    = 2'd0;
    alu_force   = 2'd0;
    reg_write   = 1'b0;
    mult_start  = 1'b0;
    uart_rx_ack = 1'b0;
    case (r_state)
      ST_FETCH: begin
        ir_write  = 1'b1;
        pc_en     = 1'b1;
        alu_srcb  = 2'd1;
        alu_force = 2'd1;
      end
      ST_DECODE: begin
        alu_srcb  = 2'd3;
        alu_force = 2'd1;
      end
      ST_MEMADR: begin
        alu_srca  = 1'b1;
        alu_srcb  = 2'd2;
        alu_force = 2'd1;
      end
      ST_MEMREAD:  iord = 1'b1;
      ST_MEMWB:    reg_write = 1'b1;
      ST_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXEC: begin
        alu_srca = 1'b1;
        alu_srcb = alu_srcb_dec;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        alu_srca  = 1'b1;
        alu_srcb  = alu_srcb_dec;
      end
      ST_BRANCH: begin
        alu_srca  = 1'b1;
        alu_force = 2'd2;
        pc_src    = 2'd1;
        // opcode[0] separates bne (0x05) from beq (0x04)
        pc_en     = opcode[0] ? ~zero : zero;
      end
      ST_JUMP: begin
        pc_en     = 1'b1;
        pc_src    = 2'd2;
        reg_write = (opcode == OP_JAL);
      end
      ST_JR: begin
        pc_en  = 1'b1;
        pc_src = 2'd3;
      end
      ST_MULT: begin
        alu_srca   = 1'b1;
        mult_start = 1'b1;
      end
      ST_UARTWB: begin
        reg_write   = 1'b1;
        uart_rx_ack = 1'b1;
        alu_srcb    = 2'd2;
      end
      default: ;
    endcase
  end

  assign state_o = r_state;

endmodule
